// File: rtl/reg_arb_pkg.sv
// ============================================================================
// Module      : reg_arb_pkg
// Description : Shared state encoding and parameter defaults for the
//               register-bank arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package reg_arb_pkg;

    localparam int NREQ_DEF = 4;
    localparam int DW_DEF   = 8;
    localparam int NREG_DEF = 4;
    localparam int AW_DEF   = 2;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/reg_bank_arbiter_rr_pick.sv
// ============================================================================
// Module      : rr_pick
// Description : Combinational winner search, starting at ptr and wrapping
//               upward modulo NREQ; returns winner index and a valid flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick
    import reg_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [PW-1:0]   idx,
    output logic            valid
);

    logic [PW:0] cand;

    // Scan from the farthest offset down so the nearest requester wins last.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        cand  = '0;
        for (int o = NREQ - 1; o >= 0; o--) begin
            cand = {1'b0, ptr} + (PW + 1)'(o);
            if (cand >= (PW + 1)'(NREQ)) begin
                cand = cand - (PW + 1)'(NREQ);
            end
            if (req[cand[PW-1:0]]) begin
                idx   = cand[PW-1:0];
                valid = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/reg_bank_arbiter.sv
// ============================================================================
// Module      : reg_bank_arbiter
// Description : Register bank shared by NREQ requesters, one read or write per
//               grant. Define REG_ARB_RR_EN for round-robin, else fixed priority.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_bank_arbiter
    import reg_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int DW   = DW_DEF,
    parameter int NREG = NREG_DEF,
    parameter int AW   = AW_DEF
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      wr,
    input  logic [NREQ*AW-1:0]   addr,
    input  logic [NREQ*DW-1:0]   wdata,
    output logic [NREQ-1:0]      gnt,
    output logic [DW-1:0]        rdata,
    output logic                 rvalid,
    output logic [NREG*DW-1:0]   reg_q
);

    localparam int PW = $clog2(NREQ);

    state_t            state_q, state_d;
    logic [PW-1:0]     win_q, win_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [DW-1:0]     rdata_q, rdata_d;
    logic              rvalid_q, rvalid_d;
    logic [DW-1:0]     bank_q [NREG];
    logic [DW-1:0]     bank_d [NREG];

    logic [PW-1:0]     ptr;
    logic [PW-1:0]     pick_idx;
    logic              pick_valid;

    logic              sel_wr;
    logic [AW-1:0]     sel_addr;
    logic [DW-1:0]     sel_wdata;

`ifdef REG_ARB_RR_EN
    logic [PW-1:0]     ptr_q, ptr_d;
    assign ptr = ptr_q;
`else
    assign ptr = '0;
`endif

    rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .req   (req),
        .ptr   (ptr),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    always_comb begin
        state_d   = state_q;
        win_d     = win_q;
        gnt_d     = '0;
        rdata_d   = rdata_q;
        rvalid_d  = 1'b0;
        bank_d    = bank_q;
`ifdef REG_ARB_RR_EN
        ptr_d     = ptr_q;
`endif
        sel_wr    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;

        for (int k = 0; k < NREQ; k++) begin
            if (win_q == PW'(k)) begin
                sel_wr    = wr[k];
                sel_addr  = addr[k*AW +: AW];
                sel_wdata = wdata[k*DW +: DW];
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d         = ST_ACCESS;
                    win_d           = pick_idx;
                    gnt_d[pick_idx] = 1'b1;
                end
            end
            ST_ACCESS: begin
                state_d = ST_IDLE;
                // Addresses with no matching register fall through: write dropped, read yields 0.
                if (sel_wr) begin
                    for (int r = 0; r < NREG; r++) begin
                        if (sel_addr == AW'(r)) begin
                            bank_d[r] = sel_wdata;
                        end
                    end
                end else begin
                    rdata_d  = '0;
                    rvalid_d = 1'b1;
                    for (int r = 0; r < NREG; r++) begin
                        if (sel_addr == AW'(r)) begin
                            rdata_d = bank_q[r];
                        end
                    end
                end
`ifdef REG_ARB_RR_EN
                ptr_d = (win_q == PW'(NREQ - 1)) ? '0 : win_q + 1'b1;
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            win_q    <= '0;
            gnt_q    <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
`ifdef REG_ARB_RR_EN
            ptr_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            win_q    <= win_d;
            gnt_q    <= gnt_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
`ifdef REG_ARB_RR_EN
            ptr_q    <= ptr_d;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < NREG; r++) begin
                bank_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NREG; r++) begin
                bank_q[r] <= bank_d[r];
            end
        end
    end

    generate
        for (genvar k = 0; k < NREG; k++) begin : g_reg_q
            assign reg_q[k*DW +: DW] = bank_q[k];
        end
    endgenerate

    assign gnt    = gnt_q;
    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;

endmodule

`default_nettype wire

// File: tb/tb_reg_bank_arbiter.sv
// ============================================================================
// Module      : tb_reg_bank_arbiter
// Description : Self-checking bench for reg_bank_arbiter (default bank and a
//               3-register bank side by side); honours REG_ARB_RR_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_bank_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  req, wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  gnt, gnt3;
    logic [7:0]  rdata, rdata3;
    logic        rvalid, rvalid3;
    logic [31:0] reg_q;
    logic [23:0] reg_q3;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] exp_q [$];
    logic [7:0] model  [4];
    logic [7:0] model3 [3];

    always #5 clk = ~clk;

    reg_bank_arbiter #(.NREQ(4), .DW(8), .NREG(4), .AW(2)) u_dut (
        .clk (clk), .reset_n (reset_n), .req (req), .wr (wr), .addr (addr),
        .wdata (wdata), .gnt (gnt), .rdata (rdata), .rvalid (rvalid), .reg_q (reg_q)
    );

    reg_bank_arbiter #(.NREQ(4), .DW(8), .NREG(3), .AW(2)) u_dut3 (
        .clk (clk), .reset_n (reset_n), .req (req), .wr (wr), .addr (addr),
        .wdata (wdata), .gnt (gnt3), .rdata (rdata3), .rvalid (rvalid3), .reg_q (reg_q3)
    );

    function automatic logic [31:0] pack4();
        return {model[3], model[2], model[1], model[0]};
    endfunction

    function automatic logic [23:0] pack3();
        return {model3[2], model3[1], model3[0]};
    endfunction

    task automatic clear_models();
        for (int i = 0; i < 4; i++) model[i] = 8'h00;
        for (int i = 0; i < 3; i++) model3[i] = 8'h00;
    endtask

    // Read scoreboard for the default-size instance.
    always @(negedge clk) begin
        if (rvalid === 1'b1) begin : mon
            logic [7:0] e;
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL rdata_unexpected: rvalid with no read pending, rdata=%h", rdata);
            end else begin
                e = exp_q.pop_front();
                if (rdata !== e) begin
                    miscompares++;
                    $display("FAIL rdata: got %h expected %h", rdata, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic apply_reset();
        @(negedge clk);
        reset_n = 1'b0;
        req = '0; wr = '0; addr = '0; wdata = '0;
        @(negedge clk);
        reset_n = 1'b1;
        clear_models();
    endtask

    // One isolated access; starts and ends on a negedge with the FSM in IDLE.
    task automatic access(input int r, input bit w, input int a, input logic [7:0] d);
        logic [3:0] eg;
        logic [7:0] e3;
        eg = '0;
        eg[r] = 1'b1;
        e3 = (a < 3) ? model3[a] : 8'h00;
        req[r] = 1'b1;
        wr[r]  = w;
        addr[r*2 +: 2]  = a[1:0];
        wdata[r*8 +: 8] = d;
        if (!w) exp_q.push_back(model[a]);
        @(negedge clk);
        vectors++;
        if (gnt !== eg) begin
            miscompares++;
            $display("FAIL gnt r%0d: got %b expected %b", r, gnt, eg);
        end
        vectors++;
        if (gnt3 !== eg) begin
            miscompares++;
            $display("FAIL gnt3 r%0d: got %b expected %b", r, gnt3, eg);
        end
        vectors++;
        if (rvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL rvalid_in_access: got %b expected 0", rvalid);
        end
        req[r] = 1'b0;
        @(negedge clk);
        if (w) begin
            model[a] = d;
            if (a < 3) model3[a] = d;
        end
        vectors++;
        if (reg_q !== pack4()) begin
            miscompares++;
            $display("FAIL reg_q: got %h expected %h", reg_q, pack4());
        end
        vectors++;
        if (reg_q3 !== pack3()) begin
            miscompares++;
            $display("FAIL reg_q3: got %h expected %h", reg_q3, pack3());
        end
        vectors++;
        if (rvalid !== !w) begin
            miscompares++;
            $display("FAIL rvalid: got %b expected %b", rvalid, !w);
        end
        if (!w) begin
            vectors++;
            if (rvalid3 !== 1'b1 || rdata3 !== e3) begin
                miscompares++;
                $display("FAIL rdata3: got v=%b d=%h expected v=1 d=%h", rvalid3, rdata3, e3);
            end
        end
        wr[r] = 1'b0;
        addr[r*2 +: 2]  = 2'b00;
        wdata[r*8 +: 8] = 8'h00;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        vectors++;
        if (gnt !== 4'b0000 || rvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: gnt=%b rvalid=%b expected 0000/0", gnt, rvalid);
        end
        vectors++;
        if (rdata !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_rdata: got %h expected 00", rdata);
        end
        vectors++;
        if (reg_q !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_reg_q: got %h expected 0", reg_q);
        end
        vectors++;
        if (reg_q3 !== 24'h0 || gnt3 !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_dut3: reg_q3=%h gnt3=%b expected 0", reg_q3, gnt3);
        end
        reset_n = 1'b1;
        clear_models();
    endtask

    task automatic test_single_write();
        access(2, 1'b1, 1, 8'hA5);
        vectors++;
        if (reg_q[15:8] !== 8'hA5) begin
            miscompares++;
            $display("FAIL single_write: reg1=%h expected a5", reg_q[15:8]);
        end
    endtask

    task automatic test_read_back();
        access(0, 1'b0, 1, 8'h00);
        @(negedge clk);
        vectors++;
        if (rvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL rvalid_pulse: got %b expected 0 one cycle later", rvalid);
        end
    endtask

    task automatic test_patterns();
        int          rq [8] = '{1, 3, 2, 0, 3, 1, 2, 0};
        bit          ww [8] = '{1, 1, 1, 1, 0, 0, 0, 0};
        int          aa [8] = '{0, 2, 3, 2, 0, 2, 3, 1};
        logic [7:0]  dd [8] = '{8'h3C, 8'hFF, 8'h5A, 8'h81, 8'h00, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 8; i++) access(rq[i], ww[i], aa[i], dd[i]);
    endtask

    task automatic test_out_of_range();
        access(1, 1'b1, 3, 8'h77);
        access(1, 1'b0, 3, 8'h00);
    endtask

    task automatic test_arbitration();
        logic [3:0] e;
        int idx;
        apply_reset();
        req   = 4'b1111;
        wr    = 4'b1111;
        addr  = {2'd3, 2'd2, 2'd1, 2'd0};
        wdata = {8'h13, 8'h12, 8'h11, 8'h10};
        for (int n = 1; n <= 16; n++) begin
            @(negedge clk);
            e = '0;
            if (n % 2 == 1) begin
`ifdef REG_ARB_RR_EN
                idx = ((n - 1) / 2) % 4;
`else
                idx = 0;
`endif
                e[idx] = 1'b1;
                model[idx] = 8'h10 + 8'(idx);
                if (idx < 3) model3[idx] = 8'h10 + 8'(idx);
            end
            vectors++;
            if (gnt !== e || gnt3 !== e) begin
                miscompares++;
                $display("FAIL arb_cycle%0d: gnt=%b gnt3=%b expected %b", n, gnt, gnt3, e);
            end
        end
        req = '0; wr = '0; addr = '0; wdata = '0;
        vectors++;
        if (reg_q !== pack4() || reg_q3 !== pack3()) begin
            miscompares++;
            $display("FAIL arb_bank: reg_q=%h reg_q3=%h expected %h/%h", reg_q, reg_q3, pack4(), pack3());
        end
    endtask

    task automatic test_reset_mid_access();
        @(negedge clk);
        req[3] = 1'b1; wr[3] = 1'b1; addr[7:6] = 2'd2; wdata[31:24] = 8'h3C;
        @(posedge clk);
        #2;
        vectors++;
        if (gnt !== 4'b1000) begin
            miscompares++;
            $display("FAIL mid_gnt_before: got %b expected 1000", gnt);
        end
        reset_n = 1'b0;
        #1;
        vectors++;
        if (gnt !== 4'b0000 || rvalid !== 1'b0 || reg_q !== 32'h0 || gnt3 !== 4'b0000) begin
            miscompares++;
            $display("FAIL mid_reset: gnt=%b rvalid=%b reg_q=%h expected 0/0/0", gnt, rvalid, reg_q);
        end
        @(negedge clk);
        reset_n = 1'b1;
        req = '0; wr = '0; addr = '0; wdata = '0;
        clear_models();
        @(negedge clk);
        vectors++;
        if (reg_q !== 32'h0 || rvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_discard: reg_q=%h rvalid=%b expected 0/0", reg_q, rvalid);
        end
        // Requesters 1 and 3 contend; lowest index wins from a reset pointer.
        req = 4'b1010;
        addr = {2'd1, 2'd0, 2'd0, 2'd0};
        exp_q.push_back(model[0]);
        @(negedge clk);
        vectors++;
        if (gnt !== 4'b0010) begin
            miscompares++;
            $display("FAIL post_reset_first: got %b expected 0010", gnt);
        end
        req[1] = 1'b0;
        @(negedge clk);
        exp_q.push_back(model[1]);
        @(negedge clk);
        vectors++;
        if (gnt !== 4'b1000) begin
            miscompares++;
            $display("FAIL post_reset_second: got %b expected 1000", gnt);
        end
        req[3] = 1'b0;
        @(negedge clk);
        addr = '0;
    endtask

    initial begin
        reset_n = 1'b0;
        req = '0; wr = '0; addr = '0; wdata = '0;
        clear_models();
        test_reset();
        test_single_write();
        test_read_back();
        test_patterns();
        test_out_of_range();
        test_arbitration();
        test_reset_mid_access();
        repeat (3) @(negedge clk);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL pending_reads: %0d reads never returned, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/reg_bank_arbiter.md
# reg_bank_arbiter

Shares a small bank of clocked data registers between several requesters. Each request is a single read or write, granted one at a time by a round-robin arbiter. The block owns the register bank: registers are updated only by the bank-update process, with next values built in separate combinational logic. It sits between requesting control blocks and any logic that consumes the bank contents through `reg_q`.

## Interface
Parameters:
- `NREQ`, 4: number of requesters, 2..8.
- `DW`, 8: register and data width.
- `NREG`, 4: number of registers in the bank.
- `AW`, 2: address width per requester; must satisfy 2^AW ≥ NREG.

Ports:
- `clk`  input  1  sole clock; all state updates on the rising edge.
- `reset_n`  input  1  asynchronous, active-low reset.
- `req`  input  NREQ  request per requester; level, held until granted.
- `wr`  input  NREQ  per requester: 1 = write, 0 = read.
- `addr`  input  NREQ*AW  flat per-requester register index; requester i occupies bits [i*AW +: AW].
- `wdata`  input  NREQ*DW  flat per-requester write data; requester i occupies bits [i*DW +: DW].
- `gnt`  output  NREQ  one-hot grant; pulses for exactly one cycle, in ACCESS.
- `rdata`  output  DW  read data, registered.
- `rvalid`  output  1  one-cycle pulse qualifying `rdata`.
- `reg_q`  output  NREG*DW  flat bank contents; register k occupies bits [k*DW +: DW].

## Operation
- FSM has two states: IDLE and ACCESS.
  - IDLE: if `req` ≠ 0, latch the winner index and go to ACCESS. Otherwise stay in IDLE.
  - ACCESS: assert `gnt[winner]` and perform that requester's access. Always return to IDLE.
- Round-robin arbitration:
  - Pointer `ptr` is reset to 0.
  - The search for the winner starts at `ptr` and runs upward, modulo NREQ.
  - After each ACCESS, `ptr` becomes winner+1, wrapping from NREQ-1 to 0.
- Write: `reg[addr]` takes `wdata` at the rising edge that ends ACCESS.
- Read: `rdata` takes `reg[addr]` at the rising edge that ends ACCESS. `rvalid` is 1 for the following cycle.
- Out-of-range address (addr ≥ NREG): the write is dropped; a read returns 0 with `rvalid`; `gnt` is still issued.
- Request sampling and hold rule:
  - `req` is sampled only in IDLE.
  - Requesters must hold `wr`, `addr` and `wdata` stable from the `req` assertion through the `gnt` cycle.
  - A `req` withdrawn before being sampled is simply not served.
- Reset values (asynchronous): state = IDLE; `ptr` = 0; `gnt` = 0; `rvalid` = 0; `rdata` = 0; all bank registers = 0.
- Reset asserted mid-ACCESS: the pending write is discarded and no `rvalid` is issued.

## Timing
- Cycle 0: IDLE with `req` ≠ 0 → cycle 1: ACCESS, `gnt` high.
- Cycle 2: written value visible on `reg_q`; for a read, `rdata`/`rvalid` valid.
- Cycle 2 is also IDLE again, so the next grant lands in cycle 3. Peak throughput is one access per 2 cycles.
- Simultaneous requests: exactly one grant per ACCESS; losers wait with `req` held.
- Fairness: with all NREQ requesting continuously, each requester is granted once in every 2*NREQ cycles.
- Read-after-write by the same or another requester returns the new value. No bypass is needed, because accesses are serialised.

## Configuration
- `REG_ARB_RR_EN` defined: round-robin arbitration as described above.
- `REG_ARB_RR_EN` undefined: fixed priority, lowest index wins. `ptr` logic is compiled out and the search always starts at 0.

## Structure
- Package `reg_arb_pkg` holds:
  - the state typedef (IDLE, ACCESS);
  - default values of NREQ, DW, NREG and AW.
- Sub-module `rr_pick`: combinational, takes `req` and `ptr` and returns the winner index plus a valid flag. With `REG_ARB_RR_EN` undefined, it is instantiated with `ptr` tied to 0.
- The top level contains three separate processes:
  - FSM/ptr registers;
  - bank register update;
  - next-value combinational logic.

## Test plan
- Reset then single write: req[2], wr[2]=1, addr=1, wdata=0xA5 → gnt=0b0100 in cycle 1; reg_q[15:8]=0xA5 in cycle 2; rvalid stays 0.
- Read back: req[0] reads addr 1 → rdata=0xA5 with a one-cycle rvalid, 2 cycles after req is sampled.
- All four requesting continuously → grant order 0,1,2,3,0,… with one grant every 2 cycles. With `REG_ARB_RR_EN` undefined → requester 0 granted every time.
- NREG=3, write to addr 3 → bank unchanged, gnt still pulses; a read of addr 3 returns 0 with rvalid.
- reset_n driven low during ACCESS of a write of 0x3C → gnt, rvalid and reg_q go to 0 immediately. After release, the first req is granted with ptr=0 priority.
